// File: rtl/axist_csr_responder.sv
// axist_csr_responder
// CSR slave for the AXI-ST h2h test block, fully on mgmt_clk.
// Decodes the 0x5000_xxxx map, holds the packet/delay/AXI control
// registers and serves status bits and captured data windows as
// 32-bit words through a waitreq/readdatavalid handshake.
// Optional feature macro: AXIST_CSR_ERR_EN (unmapped-access error
// counter at 0x5000_100C, unmapped reads return 32'hDEAD_BEEF).
module axist_csr_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] DLY_X_RST   = 16'd12,
  parameter logic [15:0] DLY_Y_RST   = 16'd32,
  parameter logic [15:0] DLY_Z_RST   = 16'd6000
) (
  input  logic         mgmt_clk,
  input  logic         rst_n,
  input  logic [31:0]  i_wr_addr,
  input  logic [31:0]  i_wrdata,
  input  logic         i_wren,
  input  logic         i_rden,
  output logic [31:0]  o_master_readdata,
  output logic         o_master_readdatavalid,
  output logic         o_master_waitreq,
  input  logic [3:0]   i_link_sts,
  input  logic [2:0]   i_ckr_sts,
  input  logic [255:0] i_dout_first,
  input  logic [255:0] i_dout_last,
  input  logic [255:0] i_din_first,
  input  logic [255:0] i_din_last,
  output logic [31:0]  o_pkt_ctrl,
  output logic         o_pkt_start,
  output logic         o_axi_rst,
  output logic [15:0]  o_delay_x,
  output logic [15:0]  o_delay_y,
  output logic [15:0]  o_delay_z
);

  localparam logic [31:0] ADDR_PKT_CTRL = 32'h5000_1000;
  localparam logic [31:0] ADDR_CKR_STS  = 32'h5000_1004;
  localparam logic [31:0] ADDR_LINK_STS = 32'h5000_1008;
  localparam logic [31:0] ADDR_ERR_CNT  = 32'h5000_100C;
  localparam logic [31:0] ADDR_DELAY_X  = 32'h5000_2000;
  localparam logic [31:0] ADDR_DELAY_Y  = 32'h5000_2004;
  localparam logic [31:0] ADDR_DELAY_Z  = 32'h5000_2008;
  localparam logic [31:0] ADDR_AXI_CTRL = 32'h5000_3000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_WR      = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t       state_r;
  state_t       state_next_s;
  logic         take_wr_s;
  logic         take_rd_s;

  logic [31:0]  addr_w_s;
  logic [31:0]  rd_data_s;
  logic         hit_s;
  logic [7:0]   win_base_s;

  logic [31:0]  readdata_r;
  logic         readdatavalid_r;
  logic         waitreq_r;
  logic [31:0]  pkt_ctrl_r;
  logic         pkt_start_r;
  logic         axi_rst_r;
  logic [15:0]  delay_x_r;
  logic [15:0]  delay_y_r;
  logic [15:0]  delay_z_r;

  logic [3:0]   link_sync_r [SYNC_STAGES];
  logic [2:0]   ckr_sync_r  [SYNC_STAGES];
  logic [3:0]   link_s;
  logic [2:0]   ckr_s;

`ifdef AXIST_CSR_ERR_EN
  logic [7:0]   err_cnt_r;
`endif

  // Byte lanes [1:0] carry no meaning: fold them away before decoding.
  assign addr_w_s   = i_wr_addr & 32'hFFFF_FFFC;
  assign win_base_s = {addr_w_s[4:2], 5'b00000};
  assign link_s     = link_sync_r[SYNC_STAGES-1];
  assign ckr_s      = ckr_sync_r[SYNC_STAGES-1];

  // Status synchronizer chains for the asynchronous link/checker inputs.
  always_ff @(posedge mgmt_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        link_sync_r[i] <= 4'h0;
        ckr_sync_r[i]  <= 3'h0;
      end
    end else begin
      link_sync_r[0] <= i_link_sts;
      ckr_sync_r[0]  <= i_ckr_sts;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        link_sync_r[i] <= link_sync_r[i-1];
        ckr_sync_r[i]  <= ckr_sync_r[i-1];
      end
    end
  end

  // Address decode: read data mux plus "mapped" flag shared by reads and writes.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    hit_s     = 1'b0;
    case (addr_w_s)
      ADDR_PKT_CTRL: begin hit_s = 1'b1; rd_data_s = pkt_ctrl_r; end
      ADDR_CKR_STS:  begin hit_s = 1'b1; rd_data_s = {28'h0, ckr_s[2], 1'b0, ckr_s[1], ckr_s[0]}; end
      ADDR_LINK_STS: begin hit_s = 1'b1; rd_data_s = {28'h0, link_s}; end
`ifdef AXIST_CSR_ERR_EN
      ADDR_ERR_CNT:  begin hit_s = 1'b1; rd_data_s = {24'h0, err_cnt_r}; end
`endif
      ADDR_DELAY_X:  begin hit_s = 1'b1; rd_data_s = {16'h0, delay_x_r}; end
      ADDR_DELAY_Y:  begin hit_s = 1'b1; rd_data_s = {16'h0, delay_y_r}; end
      ADDR_DELAY_Z:  begin hit_s = 1'b1; rd_data_s = {16'h0, delay_z_r}; end
      ADDR_AXI_CTRL: begin hit_s = 1'b1; rd_data_s = {31'h0, axi_rst_r}; end
      default: begin
        // Capture windows: 0x5000_4k00 .. 0x5000_4k1C, k selects the buffer.
        if (addr_w_s[31:12] == 20'h50004 && addr_w_s[7:5] == 3'b000) begin
          case (addr_w_s[11:8])
            4'h0:    begin hit_s = 1'b1; rd_data_s = i_dout_first[win_base_s +: 32]; end
            4'h1:    begin hit_s = 1'b1; rd_data_s = i_dout_last[win_base_s +: 32]; end
            4'h2:    begin hit_s = 1'b1; rd_data_s = i_din_first[win_base_s +: 32]; end
            4'h3:    begin hit_s = 1'b1; rd_data_s = i_din_last[win_base_s +: 32]; end
            default: begin hit_s = 1'b0; rd_data_s = 32'h0000_0000; end
          endcase
        end else begin
          hit_s     = 1'b0;
          rd_data_s = 32'h0000_0000;
        end
      end
    endcase
`ifdef AXIST_CSR_ERR_EN
    if (!hit_s) begin
      rd_data_s = 32'hDEAD_BEEF;
    end else begin
      rd_data_s = rd_data_s;
    end
`endif
  end

  // Handshake FSM next state: write wins over read, held requests wait in RELEASE.
  always_comb begin
    state_next_s = state_r;
    take_wr_s    = 1'b0;
    take_rd_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_wren) begin
          take_wr_s    = 1'b1;
          state_next_s = ST_WR;
        end else if (i_rden) begin
          take_rd_s    = 1'b1;
          state_next_s = ST_RD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RD:   state_next_s = ST_RELEASE;
      ST_WR:   state_next_s = ST_RELEASE;
      ST_RELEASE: begin
        if (!i_wren && !i_rden) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RELEASE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge mgmt_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handshake outputs are loaded on the accepting edge so they show during RD/WR.
  always_ff @(posedge mgmt_clk or negedge rst_n) begin
    if (!rst_n) begin
      waitreq_r       <= 1'b1;
      readdatavalid_r <= 1'b0;
      readdata_r      <= 32'h0000_0000;
    end else begin
      waitreq_r       <= ~(take_wr_s | take_rd_s);
      readdatavalid_r <= take_rd_s;
      if (take_rd_s) begin
        readdata_r <= rd_data_s;
      end
    end
  end

  // Register file: writes commit on the accepting edge straight from the bus.
  always_ff @(posedge mgmt_clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_ctrl_r  <= 32'h0000_0000;
      pkt_start_r <= 1'b0;
      axi_rst_r   <= 1'b0;
      delay_x_r   <= DLY_X_RST;
      delay_y_r   <= DLY_Y_RST;
      delay_z_r   <= DLY_Z_RST;
    end else begin
      pkt_start_r <= take_wr_s && (addr_w_s == ADDR_PKT_CTRL) && i_wrdata[0];
      if (take_wr_s) begin
        case (addr_w_s)
          ADDR_PKT_CTRL: pkt_ctrl_r <= i_wrdata;
          ADDR_DELAY_X:  delay_x_r  <= i_wrdata[15:0];
          ADDR_DELAY_Y:  delay_y_r  <= i_wrdata[15:0];
          ADDR_DELAY_Z:  delay_z_r  <= i_wrdata[15:0];
          ADDR_AXI_CTRL: axi_rst_r  <= i_wrdata[0];
          default:       pkt_ctrl_r <= pkt_ctrl_r;
        endcase
      end
    end
  end

`ifdef AXIST_CSR_ERR_EN
  // Saturating count of unmapped accesses; any write to its address clears it.
  always_ff @(posedge mgmt_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'h00;
    end else if (take_wr_s && addr_w_s == ADDR_ERR_CNT) begin
      err_cnt_r <= 8'h00;
    end else if ((take_wr_s || take_rd_s) && !hit_s && err_cnt_r != 8'hFF) begin
      err_cnt_r <= err_cnt_r + 8'h01;
    end
  end
`endif

  assign o_master_readdata      = readdata_r;
  assign o_master_readdatavalid = readdatavalid_r;
  assign o_master_waitreq       = waitreq_r;
  assign o_pkt_ctrl             = pkt_ctrl_r;
  assign o_pkt_start            = pkt_start_r;
  assign o_axi_rst              = axi_rst_r;
  assign o_delay_x              = delay_x_r;
  assign o_delay_y              = delay_y_r;
  assign o_delay_z              = delay_z_r;

endmodule

// File: tb/tb_axist_csr_responder.sv
// Directed bench for axist_csr_responder: read expectations go into a
// scoreboard queue when a read is issued and are checked when
// readdatavalid strobes. Honours AXIST_CSR_ERR_EN if defined.
module tb_axist_csr_responder;

  logic         mgmt_clk = 1'b0;
  logic         rst_n;
  logic [31:0]  i_wr_addr;
  logic [31:0]  i_wrdata;
  logic         i_wren;
  logic         i_rden;
  logic [31:0]  o_master_readdata;
  logic         o_master_readdatavalid;
  logic         o_master_waitreq;
  logic [3:0]   i_link_sts;
  logic [2:0]   i_ckr_sts;
  logic [255:0] i_dout_first;
  logic [255:0] i_dout_last;
  logic [255:0] i_din_first;
  logic [255:0] i_din_last;
  logic [31:0]  o_pkt_ctrl;
  logic         o_pkt_start;
  logic         o_axi_rst;
  logic [15:0]  o_delay_x;
  logic [15:0]  o_delay_y;
  logic [15:0]  o_delay_z;

  int tests = 0;
  int fails = 0;
  int rdv_count = 0;
  int start_count = 0;
  logic [31:0] exp_q [$];

  axist_csr_responder dut (
    .mgmt_clk               (mgmt_clk),
    .rst_n                  (rst_n),
    .i_wr_addr              (i_wr_addr),
    .i_wrdata               (i_wrdata),
    .i_wren                 (i_wren),
    .i_rden                 (i_rden),
    .o_master_readdata      (o_master_readdata),
    .o_master_readdatavalid (o_master_readdatavalid),
    .o_master_waitreq       (o_master_waitreq),
    .i_link_sts             (i_link_sts),
    .i_ckr_sts              (i_ckr_sts),
    .i_dout_first           (i_dout_first),
    .i_dout_last            (i_dout_last),
    .i_din_first            (i_din_first),
    .i_din_last             (i_din_last),
    .o_pkt_ctrl             (o_pkt_ctrl),
    .o_pkt_start            (o_pkt_start),
    .o_axi_rst              (o_axi_rst),
    .o_delay_x              (o_delay_x),
    .o_delay_y              (o_delay_y),
    .o_delay_z              (o_delay_z)
  );

  always #5 mgmt_clk = ~mgmt_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: count strobes and score read data on the falling edge.
  always @(negedge mgmt_clk) begin
    if (o_pkt_start === 1'b1) start_count++;
    if (o_master_readdatavalid === 1'b1) begin
      rdv_count++;
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_rdv: observed data %h expected no strobe", o_master_readdata);
      end
      if (exp_q.size() != 0) check("readdata", o_master_readdata, exp_q.pop_front());
    end
  end

  // One handshake: drive request, hold until waitreq seen low, then idle out.
  task automatic access(input logic [31:0] addr, input logic [31:0] data,
                        input logic wr, input logic rd);
    logic seen;
    seen = 1'b0;
    @(negedge mgmt_clk);
    i_wr_addr = addr; i_wrdata = data; i_wren = wr; i_rden = rd;
    for (int i = 0; i < 16; i++) begin
      @(posedge mgmt_clk); #1;
      if (o_master_waitreq === 1'b0) begin seen = 1'b1; break; end
    end
    i_wren = 1'b0; i_rden = 1'b0;
    check("accept", {31'h0, seen}, 32'h1);
    repeat (3) @(posedge mgmt_clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    access(addr, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    access(addr, data, 1'b1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] ramp;
    logic [31:0]  w;
    int           s0, r0;
    for (int i = 0; i < 32; i++) ramp[i*8 +: 8] = 8'(i);
    rst_n = 1'b0; i_wr_addr = 32'h0; i_wrdata = 32'h0; i_wren = 1'b0; i_rden = 1'b0;
    i_link_sts = 4'h0; i_ckr_sts = 3'h0;
    i_dout_first = ramp; i_dout_last = ~ramp;
    i_din_first = {8{32'hA5A5_0000}}; i_din_last = ramp;
    repeat (3) @(posedge mgmt_clk);
    #1;
    // Reset state
    check("rst_waitreq", {31'h0, o_master_waitreq}, 32'h1);
    check("rst_rdv", {31'h0, o_master_readdatavalid}, 32'h0);
    check("rst_readdata", o_master_readdata, 32'h0);
    check("rst_pkt_ctrl", o_pkt_ctrl, 32'h0);
    check("rst_axi_rst", {31'h0, o_axi_rst}, 32'h0);
    check("rst_delay_x", {16'h0, o_delay_x}, 32'd12);
    check("rst_delay_y", {16'h0, o_delay_y}, 32'd32);
    check("rst_delay_z", {16'h0, o_delay_z}, 32'd6000);
    @(negedge mgmt_clk); rst_n = 1'b1;
    repeat (2) @(posedge mgmt_clk); #1;
    check("idle_waitreq", {31'h0, o_master_waitreq}, 32'h1);

    do_read(32'h5000_2000, 32'd12);
    do_read(32'h5000_2004, 32'd32);
    do_read(32'h5000_2008, 32'd6000);
    do_read(32'h5000_3000, 32'd0);

    // Packet control: start pulse only when bit0 set
    s0 = start_count;
    do_write(32'h5000_1000, 32'h0000_0FF5);
    check("pkt_start_pulses", 32'(start_count - s0), 32'd1);
    check("pkt_ctrl", o_pkt_ctrl, 32'h0000_0FF5);
    do_read(32'h5000_1000, 32'h0000_0FF5);
    s0 = start_count;
    do_write(32'h5000_1000, 32'h0000_0FF4);
    check("pkt_no_start", 32'(start_count - s0), 32'd0);
    check("pkt_ctrl2", o_pkt_ctrl, 32'h0000_0FF4);

    // Link status through the synchronizer; held read gives one strobe
    i_link_sts = 4'hF;
    repeat (4) @(posedge mgmt_clk);
    do_read(32'h5000_1008, 32'h0000_000F);
    r0 = rdv_count;
    exp_q.push_back(32'h0000_000F);
    @(negedge mgmt_clk); i_wr_addr = 32'h5000_1008; i_rden = 1'b1;
    repeat (20) @(posedge mgmt_clk);
    #1; i_rden = 1'b0;
    repeat (3) @(posedge mgmt_clk); #1;
    check("held_rd_strobes", 32'(rdv_count - r0), 32'd1);

    // Capture windows
    for (int k = 0; k < 8; k++) begin
      w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      do_read(32'h5000_4000 + 32'(4*k), w);
      do_read(32'h5000_4300 + 32'(4*k), w);
    end
    do_read(32'h5000_4104, 32'hF8F9_FAFB);
    do_read(32'h5000_421C, 32'hA5A5_0000);
    do_read(32'h5000_4020, 32'h0000_0000 `ifdef AXIST_CSR_ERR_EN | 32'hDEAD_BEEF `endif);

    // Checker status
    i_ckr_sts = 3'b111;
    repeat (4) @(posedge mgmt_clk);
    do_read(32'h5000_1004, 32'h0000_000B);
    i_ckr_sts = 3'b010;
    repeat (4) @(posedge mgmt_clk);
    do_read(32'h5000_1004, 32'h0000_0002);

    // Simultaneous write and read: write wins, no strobe
    r0 = rdv_count;
    access(32'h5000_3000, 32'h0000_0001, 1'b1, 1'b1);
    check("wr_rd_no_strobe", 32'(rdv_count - r0), 32'd0);
    check("axi_rst_set", {31'h0, o_axi_rst}, 32'h1);
    do_read(32'h5000_3000, 32'h0000_0001);
    do_write(32'h5000_3000, 32'hFFFF_FFFE);
    check("axi_rst_clr", {31'h0, o_axi_rst}, 32'h0);

    // Delay register width and RO write
    do_write(32'h5000_2004, 32'hABCD_1234);
    check("delay_y_wr", {16'h0, o_delay_y}, 32'h0000_1234);
    do_read(32'h5000_2004, 32'h0000_1234);
    do_write(32'h5000_1008, 32'h0000_0000);
    do_read(32'h5000_1008, 32'h0000_000F);

    // Unmapped access
`ifdef AXIST_CSR_ERR_EN
    do_write(32'h5000_100C, 32'h0000_0000);
    do_read(32'h5000_5000, 32'hDEAD_BEEF);
    do_read(32'h5000_100C, 32'h0000_0001);
    do_write(32'h5000_6000, 32'h1234_5678);
    do_read(32'h5000_100C, 32'h0000_0002);
    do_write(32'h5000_100C, 32'h0000_0055);
    do_read(32'h5000_100C, 32'h0000_0000);
`else
    do_read(32'h5000_5000, 32'h0000_0000);
    do_read(32'h5000_100C, 32'h0000_0000);
`endif

    // Reset during RD: access lost, outputs back to reset values
    r0 = rdv_count;
    @(negedge mgmt_clk); i_wr_addr = 32'h5000_2000; i_rden = 1'b1;
    @(posedge mgmt_clk); #1;
    rst_n = 1'b0;
    #1; i_rden = 1'b0;
    repeat (2) @(posedge mgmt_clk); #1;
    check("midrst_no_strobe", 32'(rdv_count - r0), 32'd0);
    check("midrst_waitreq", {31'h0, o_master_waitreq}, 32'h1);
    check("midrst_readdata", o_master_readdata, 32'h0);
    check("midrst_delay_y", {16'h0, o_delay_y}, 32'd32);
    check("midrst_pkt_ctrl", o_pkt_ctrl, 32'h0);
    @(negedge mgmt_clk); rst_n = 1'b1;
    repeat (2) @(posedge mgmt_clk);
    do_read(32'h5000_2000, 32'd12);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
